game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter REFRESH_TIMEOUT, default 255: max clk cycles to wait for refreshed after step.
REQ-002 Parameter SCORE_W, default 8: score counter width.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 clk_div  in  1  game-rate divided clock; sampled as data.
REQ-006 start  in  1  one-cycle request to begin or restart a game.
REQ-007 dir1_in, dir2_in  in  direction  player direction requests; NONE means no new request.
REQ-008 refreshed  in  1  map updater reports new map/map_nxt valid.
REQ-009 eaten1, eaten2, won, lost, draw  in  1 each  registered collision results.
REQ-010 mode  out  game_mode  current game mode.
REQ-011 dir1, dir2  out  direction  latched directions driving map updater and collision logic.
REQ-012 step  out  1  one-cycle pulse: advance map one move.
REQ-013 map_init  out  1  one-cycle pulse: reload initial map.
REQ-014 grow1, grow2  out  1  one-cycle pulses: snake lengthens / respawn point.
REQ-015 score1, score2  out  SCORE_W  points eaten this game.
REQ-016 timeout_err, overrun_err  out  1  sticky fault flags.

Function
REQ-017 clk_div SHALL pass through two flops; tick = reg & ~prv, one clk cycle, exactly once per clk_div rising edge.
REQ-018 FSM states: IDLE, WAIT_TICK, STEP, WAIT_REFRESH, CHECK, OVER.
REQ-019 IDLE: mode=MENU; start -> WAIT_TICK, with map_init pulse, scores cleared, dir1/dir2 set to NONE, in same transition cycle.
REQ-020 WAIT_TICK: mode=GAME; tick -> STEP; in that cycle dir1 <= dir1_in unless dir1_in==NONE or dir1_in is exact reverse of current non-NONE dir1 (then hold); same for dir2.
REQ-021 STEP: step=1 for exactly one cycle; -> WAIT_REFRESH; timeout counter cleared.
REQ-022 WAIT_REFRESH: refreshed -> CHECK next cycle; counter increments each cycle; counter reaching REFRESH_TIMEOUT without refreshed -> set timeout_err, -> WAIT_TICK (move abandoned, no score change).
REQ-023 CHECK (one cycle, collision results valid): draw -> OVER/DRAW; else lost -> OVER/LOST; else won -> OVER/WON; else -> WAIT_TICK.
REQ-024 CHECK: eaten1 -> grow1 pulse, score1+1; eaten2 likewise; applied even when game ends in same cycle.
REQ-025 Scores SHALL saturate at 2^SCORE_W-1; no wrap.
REQ-026 OVER: mode = WON, LOST or DRAW as latched; step/grow never asserted; start -> WAIT_TICK as in REQ-019.
REQ-027 tick arriving in STEP, WAIT_REFRESH or CHECK SHALL be dropped and set overrun_err; ticks in IDLE/OVER ignored silently.
REQ-028 start outside IDLE/OVER SHALL be ignored.
REQ-029 step, map_init, grow1, grow2 SHALL never be high for two consecutive cycles.
REQ-030 Sticky flags clear only on rst or on start-triggered game restart.

Reset
REQ-031 rst: state IDLE, mode=MENU, dir1=dir2=NONE, scores 0, all pulses 0, flags 0, timeout counter 0, edge-detect flops 0.
REQ-032 rst mid-game SHALL abort immediately; first post-reset cycle identical to power-up IDLE; no step or grow emitted.

Structure
REQ-033 game_mode SHALL gain MENU, WON, LOST, DRAW values in snake_pkg; direction (with NONE) stays in snake_pkg; state enum local.
REQ-034 Edge detector SHALL be sub-module tick_detect (clk, rst, clk_div -> tick).
REQ-035 Outputs SHALL be registered; no combinational input-to-output path.

Verification
REQ-036 Scenario: rst, start, clk_div period 20 clk, refreshed 3 cycles after step, no events -> one step per clk_div edge, mode=GAME, scores 0.
REQ-037 Scenario: eaten1=1 in CHECK for 3 moves -> three grow1 pulses, score1=3, score2=0.
REQ-038 Scenario: CHECK with won=1, lost=1, draw=1, eaten2=1 -> mode=DRAW, score2+1, no further step; start -> map_init, scores 0.
REQ-039 Scenario: dir1=RIGHT, dir1_in=LEFT on tick -> dir1 stays RIGHT; dir1_in=UP -> dir1=UP.
REQ-040 Scenario: refreshed withheld, REFRESH_TIMEOUT=8 -> timeout_err after 8 cycles, return to WAIT_TICK; extra tick during WAIT_REFRESH -> overrun_err.
REQ-041 Scenario: score1=255 plus eaten1 -> score1 stays 255; rst during WAIT_REFRESH -> mode=MENU next cycle, all outputs at reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake game: game modes, directions and direction helpers.
package snake_pkg;

  typedef enum logic [2:0] {
    MENU = 3'd0,
    GAME = 3'd1,
    WON  = 3'd2,
    LOST = 3'd3,
    DRAW = 3'd4
  } game_mode_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction_t;

  // True when req points exactly opposite to cur.
  function automatic logic is_reverse(input direction_t cur, input direction_t req);
    logic rev;
    case (cur)
      UP:      rev = (req == DOWN);
      DOWN:    rev = (req == UP);
      LEFT:    rev = (req == RIGHT);
      RIGHT:   rev = (req == LEFT);
      default: rev = 1'b0;
    endcase
    return rev;
  endfunction

  // New latched direction: NONE keeps the current one, and so does a U-turn
  // (a snake cannot reverse into its own body).
  function automatic direction_t next_dir(input direction_t cur, input direction_t req);
    direction_t nd;
    if (req == NONE) begin
      nd = cur;
    end else if ((cur != NONE) && is_reverse(cur, req)) begin
      nd = cur;
    end else begin
      nd = req;
    end
    return nd;
  endfunction

endpackage

// File: rtl/tick_detect.sv
// Turns the slow game-rate clock into a one-cycle tick per rising edge.
// clk_div is treated as data: one sampling flop, one history flop.
module tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  output logic tick
);

  logic sync_q;
  logic prv_q;

  // Sample clk_div and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      prv_q  <= 1'b0;
    end else begin
      sync_q <= clk_div;
      prv_q  <= sync_q;
    end
  end

  assign tick = sync_q & ~prv_q;

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: paces snake moves on the game-rate tick, hands each move to
// the map updater, waits for the refreshed map, then applies collision results.
// All outputs come straight from flops.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int REFRESH_TIMEOUT = 255,
  parameter int SCORE_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  input  logic               start,
  input  direction_t         dir1_in,
  input  direction_t         dir2_in,
  input  logic               refreshed,
  input  logic               eaten1,
  input  logic               eaten2,
  input  logic               won,
  input  logic               lost,
  input  logic               draw,
  output game_mode_t         mode,
  output direction_t         dir1,
  output direction_t         dir2,
  output logic               step,
  output logic               map_init,
  output logic               grow1,
  output logic               grow2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               timeout_err,
  output logic               overrun_err
);

  localparam int CNT_W = $clog2(REFRESH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_TICK    = 3'd1,
    STEP         = 3'd2,
    WAIT_REFRESH = 3'd3,
    CHECK        = 3'd4,
    OVER         = 3'd5
  } state_t;

  state_t             state_q, state_d;
  game_mode_t         mode_q, mode_d;
  game_mode_t         result_q, result_d;
  direction_t         dir1_q, dir1_d, dir2_q, dir2_d;
  logic               step_q, step_d, map_init_q, map_init_d;
  logic               grow1_q, grow1_d, grow2_q, grow2_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               tout_q, tout_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_s;
  logic               busy_s;

  // Saturating increment: scores stick at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == {SCORE_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + SCORE_W'(1);
    end
    return r;
  endfunction

  tick_detect u_tick_detect (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .tick    (tick_s)
  );

  // A tick is an overrun only while a move is still in flight.
  assign busy_s = (state_q == STEP) || (state_q == WAIT_REFRESH) || (state_q == CHECK);

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    dir1_d     = dir1_q;
    dir2_d     = dir2_q;
    step_d     = 1'b0;
    map_init_d = 1'b0;
    grow1_d    = 1'b0;
    grow2_d    = 1'b0;
    score1_d   = score1_q;
    score2_d   = score2_q;
    cnt_d      = cnt_q;
    tout_d     = tout_q;
    ovr_d      = ovr_q | (tick_s & busy_s);
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = WAIT_TICK;
          map_init_d = 1'b1;
          score1_d   = {SCORE_W{1'b0}};
          score2_d   = {SCORE_W{1'b0}};
          dir1_d     = NONE;
          dir2_d     = NONE;
          tout_d     = 1'b0;
          ovr_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      WAIT_TICK: begin
        if (tick_s) begin
          state_d = STEP;
          step_d  = 1'b1;
          dir1_d  = next_dir(dir1_q, dir1_in);
          dir2_d  = next_dir(dir2_q, dir2_in);
        end else begin
          state_d = WAIT_TICK;
        end
      end
      STEP: begin
        state_d = WAIT_REFRESH;
        cnt_d   = {CNT_W{1'b0}};
      end
      WAIT_REFRESH: begin
        if (refreshed) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(REFRESH_TIMEOUT)) begin
            tout_d  = 1'b1;
            state_d = WAIT_TICK;
          end else begin
            state_d = WAIT_REFRESH;
          end
        end
      end
      CHECK: begin
        grow1_d = eaten1;
        grow2_d = eaten2;
        if (eaten1) begin
          score1_d = sat_inc(score1_q);
        end else begin
          score1_d = score1_q;
        end
        if (eaten2) begin
          score2_d = sat_inc(score2_q);
        end else begin
          score2_d = score2_q;
        end
        if (draw) begin
          state_d  = OVER;
          result_d = DRAW;
        end else if (lost) begin
          state_d  = OVER;
          result_d = LOST;
        end else if (won) begin
          state_d  = OVER;
          result_d = WON;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    case (state_d)
      IDLE:    mode_d = MENU;
      OVER:    mode_d = result_d;
      default: mode_d = GAME;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MENU;
      result_q   <= MENU;
      dir1_q     <= NONE;
      dir2_q     <= NONE;
      step_q     <= 1'b0;
      map_init_q <= 1'b0;
      grow1_q    <= 1'b0;
      grow2_q    <= 1'b0;
      score1_q   <= {SCORE_W{1'b0}};
      score2_q   <= {SCORE_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      tout_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      dir1_q     <= dir1_d;
      dir2_q     <= dir2_d;
      step_q     <= step_d;
      map_init_q <= map_init_d;
      grow1_q    <= grow1_d;
      grow2_q    <= grow2_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      ovr_q      <= ovr_d;
    end
  end

  assign mode        = mode_q;
  assign dir1        = dir1_q;
  assign dir2        = dir2_q;
  assign step        = step_q;
  assign map_init    = map_init_q;
  assign grow1       = grow1_q;
  assign grow2       = grow2_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign timeout_err = tout_q;
  assign overrun_err = ovr_q;

endmodule
